// File: rtl/xfer_scheduler_if.sv
// Handshake and queue-control bundle between the transfer scheduler, the
// deserializer, the user dequeue button and the byte queue.
interface xfer_scheduler_if;
    logic       des_ready_in;
    logic [7:0] des_data_in;
    logic       ack_out;
    logic       enq_out;
    logic [7:0] enq_data_out;
    logic       deq_req_in;
    logic       deq_out;
    logic [3:0] len_in;
    logic       busy_out;
    logic [7:0] drop_cnt_out;

    modport slave (
        input  des_ready_in, des_data_in, deq_req_in, len_in,
        output ack_out, enq_out, enq_data_out, deq_out, busy_out, drop_cnt_out
    );

    modport master (
        output des_ready_in, des_data_in, deq_req_in, len_in,
        input  ack_out, enq_out, enq_data_out, deq_out, busy_out, drop_cnt_out
    );
endinterface

// File: rtl/xfer_scheduler.sv
// Round-robin enqueue/dequeue sequencer for the 8-entry byte queue.
// Optional feature macro: DROP_ON_FULL_EN (ack and count bytes that arrive while full).
module xfer_scheduler #(
    parameter int DEPTH    = 8,
    parameter int ENQ_HOLD = 1,
    parameter int DEQ_HOLD = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    xfer_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ENQ, S_ACK, S_DEQ} state_t;

    localparam logic [3:0] C_DEPTH      = 4'(DEPTH);
    localparam logic [3:0] C_ENQ_RELOAD = 4'(ENQ_HOLD - 1);
    localparam logic [3:0] C_DEQ_RELOAD = 4'(DEQ_HOLD - 1);

    state_t     r_state;
    logic       r_enq;
    logic       r_deq;
    logic       r_ack;
    logic       r_busy;
    logic       r_last_deq;
    logic       r_deq_armed_n;
    logic [7:0] r_enq_data;
    logic [3:0] r_hold;

    logic w_enq_ok;
    logic w_deq_ok;
    logic w_grant_enq;
    logic w_grant_deq;
    logic w_drop;

    assign w_enq_ok    = bus.des_ready_in && (bus.len_in < C_DEPTH);
    assign w_deq_ok    = bus.deq_req_in && !r_deq_armed_n && (bus.len_in != 4'd0);
    // Under contention the side that did not win last time gets the grant.
    assign w_grant_enq = w_enq_ok && (!w_deq_ok || r_last_deq);
    assign w_grant_deq = w_deq_ok && !w_grant_enq;

`ifdef DROP_ON_FULL_EN
    logic [7:0] r_drop_cnt;

    assign w_drop = bus.des_ready_in && (bus.len_in == C_DEPTH) && !w_grant_deq;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if ((r_state == S_IDLE) && w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.drop_cnt_out = r_drop_cnt;
`else
    assign w_drop           = 1'b0;
    assign bus.drop_cnt_out = 8'd0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_enq         <= 1'b0;
            r_deq         <= 1'b0;
            r_ack         <= 1'b0;
            r_busy        <= 1'b0;
            r_last_deq    <= 1'b1;
            r_deq_armed_n <= 1'b0;
            r_enq_data    <= 8'd0;
            r_hold        <= 4'd0;
        end else begin
            // A press re-arms only once the button has been seen released.
            if (!bus.deq_req_in) begin
                r_deq_armed_n <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_grant_enq) begin
                        r_state    <= S_ENQ;
                        r_enq      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_enq_data <= bus.des_data_in;
                        r_hold     <= C_ENQ_RELOAD;
                        r_last_deq <= 1'b0;
                    end else if (w_grant_deq) begin
                        r_state       <= S_DEQ;
                        r_deq         <= 1'b1;
                        r_busy        <= 1'b1;
                        r_hold        <= C_DEQ_RELOAD;
                        r_last_deq    <= 1'b1;
                        r_deq_armed_n <= 1'b1;
                    end else if (w_drop) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_ENQ: begin
                    if (r_hold == 4'd0) begin
                        r_state <= S_ACK;
                        r_enq   <= 1'b0;
                        r_ack   <= 1'b1;
                    end else begin
                        r_hold <= r_hold - 4'd1;
                    end
                end
                S_ACK: begin
                    if (!bus.des_ready_in) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_DEQ: begin
                    if (r_hold == 4'd0) begin
                        r_state <= S_IDLE;
                        r_deq   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold <= r_hold - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.enq_out      = r_enq;
    assign bus.deq_out      = r_deq;
    assign bus.ack_out      = r_ack;
    assign bus.busy_out     = r_busy;
    assign bus.enq_data_out = r_enq_data;

    a_strobe_mutex: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(r_enq && r_deq));
endmodule

// File: tb/tb_xfer_scheduler.sv
// Self-checking bench for xfer_scheduler: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_xfer_scheduler;
    localparam int DEPTH    = 8;
    localparam int ENQ_HOLD = 1;
    localparam int DEQ_HOLD = 1;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    always #5 i_clk = ~i_clk;

    xfer_scheduler_if bus ();

    xfer_scheduler #(
        .DEPTH    (DEPTH),
        .ENQ_HOLD (ENQ_HOLD),
        .DEQ_HOLD (DEQ_HOLD)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remaining strobe cycles per transfer, ack-phase flag, arbitration memory.
    int         m_enq_left;
    int         m_deq_left;
    bit         m_in_ack;
    bit         m_last_deq;
    bit         m_armed;
    logic [7:0] m_data;
    int         m_drops;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_enq_left = 0;
        m_deq_left = 0;
        m_in_ack   = 1'b0;
        m_last_deq = 1'b1;
        m_armed    = 1'b0;
        m_data     = 8'd0;
        m_drops    = 0;
    endtask

    task automatic model_edge();
        bit idle, armed_old, enq_ok, deq_ok, g_enq, g_deq;
        idle      = (m_enq_left == 0) && (m_deq_left == 0) && !m_in_ack;
        armed_old = m_armed;
        if (!bus.deq_req_in) m_armed = 1'b0;
        if (idle) begin
            enq_ok = bus.des_ready_in && (int'(bus.len_in) < DEPTH);
            deq_ok = bus.deq_req_in && !armed_old && (bus.len_in != 0);
            g_enq  = enq_ok && (!deq_ok || m_last_deq);
            g_deq  = deq_ok && !g_enq;
            if (g_enq) begin
                m_enq_left = ENQ_HOLD;
                m_data     = bus.des_data_in;
                m_last_deq = 1'b0;
            end else if (g_deq) begin
                m_deq_left = DEQ_HOLD;
                m_armed    = 1'b1;
                m_last_deq = 1'b1;
            end
`ifdef DROP_ON_FULL_EN
            else if (bus.des_ready_in && (int'(bus.len_in) == DEPTH)) begin
                m_in_ack = 1'b1;
                if (m_drops < 255) m_drops++;
            end
`endif
        end else if (m_enq_left > 0) begin
            m_enq_left--;
            if (m_enq_left == 0) m_in_ack = 1'b1;
        end else if (m_deq_left > 0) begin
            m_deq_left--;
        end else if (!bus.des_ready_in) begin
            m_in_ack = 1'b0;
        end
    endtask

    task automatic check_all();
        check_val("enq_out", bus.enq_out, int'(m_enq_left > 0));
        check_val("deq_out", bus.deq_out, int'(m_deq_left > 0));
        check_val("ack_out", bus.ack_out, int'(m_in_ack));
        check_val("busy_out", bus.busy_out, int'((m_enq_left > 0) || (m_deq_left > 0) || m_in_ack));
        check_val("enq_data_out", bus.enq_data_out, int'(m_data));
        check_val("drop_cnt_out", bus.drop_cnt_out, m_drops);
        check_val("strobe_mutex", int'(bus.enq_out && bus.deq_out), 0);
    endtask

    task automatic step();
        @(posedge i_clk);
        if (i_rst_n) model_edge();
        else         model_reset();
        #1;
        check_all();
    endtask

    // Deserializer side of the 4-phase handshake.
    task automatic drive_proto(input bit want_ready);
        if (bus.des_ready_in && bus.ack_out) begin
            bus.des_ready_in = 1'b0;
        end else if (!bus.des_ready_in && !bus.ack_out && want_ready) begin
            bus.des_ready_in = 1'b1;
            bus.des_data_in  = 8'($urandom);
        end
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic settle();
        bus.deq_req_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_proto(1'b0);
            step();
        end
    endtask

    initial begin
        int cnt;
        int prev_enq;
        int grants[$];

        bus.des_ready_in = 1'b0;
        bus.des_data_in  = 8'd0;
        bus.deq_req_in   = 1'b0;
        bus.len_in       = 4'd0;
        model_reset();
        step();
        step();
        check_val("reset_busy", bus.busy_out, 0);
        check_val("reset_data", bus.enq_data_out, 0);
        i_rst_n = 1'b1;

        // Reset asserted while an enqueue strobe is active.
        bus.des_ready_in = 1'b1;
        bus.des_data_in  = 8'h3C;
        step();
        check_val("t1_enq_before", bus.enq_out, 1);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_val("t1_enq_async", bus.enq_out, 0);
        check_val("t1_ack_async", bus.ack_out, 0);
        check_val("t1_busy_async", bus.busy_out, 0);
        bus.des_ready_in = 1'b0;
        step();
        i_rst_n = 1'b1;
        step();
        check_val("t1_idle_after", bus.busy_out, 0);

        // Single enqueue with handshake.
        bus.len_in       = 4'd0;
        bus.des_ready_in = 1'b1;
        bus.des_data_in  = 8'hA5;
        step();
        check_val("t2_enq", bus.enq_out, 1);
        check_val("t2_data", bus.enq_data_out, 8'hA5);
        step();
        check_val("t2_enq_off", bus.enq_out, 0);
        check_val("t2_ack", bus.ack_out, 1);
        step();
        check_val("t2_ack_hold", bus.ack_out, 1);
        bus.des_ready_in = 1'b0;
        step();
        check_val("t2_ack_fall", bus.ack_out, 0);
        settle();

        // One dequeue per press.
        bus.len_in     = 4'd3;
        bus.deq_req_in = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            cnt += int'(bus.deq_out);
        end
        check_val("t3_first_press", cnt, 1);
        bus.deq_req_in = 1'b0;
        step();
        bus.deq_req_in = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            cnt += int'(bus.deq_out);
        end
        check_val("t3_second_press", cnt, 1);
        settle();

        // Contention rounds from a fresh reset.
        apply_reset();
        bus.len_in       = 4'd4;
        bus.des_ready_in = 1'b1;
        bus.des_data_in  = 8'h11;
        bus.deq_req_in   = 1'b1;
        prev_enq = 0;
        for (int k = 0; k < 40 && grants.size() < 3; k++) begin
            step();
            if (bus.enq_out && !prev_enq) grants.push_back(0);
            if (bus.deq_out) grants.push_back(1);
            prev_enq = int'(bus.enq_out);
            bus.deq_req_in = !bus.deq_out;
            drive_proto(1'b1);
        end
        check_val("t4_grants", grants.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < grants.size()) check_val($sformatf("t4_grant%0d", i), grants[i], (i == 1) ? 1 : 0);
        end
        settle();

        // Dequeue held while empty, then the queue fills.
        bus.len_in     = 4'd0;
        bus.deq_req_in = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            cnt += int'(bus.deq_out);
        end
        check_val("t6_empty", cnt, 0);
        bus.len_in = 4'd1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            cnt += int'(bus.deq_out);
        end
        check_val("t6_filled", cnt, 1);
        settle();

        // Full queue.
        bus.len_in       = 4'd8;
        bus.des_ready_in = 1'b1;
`ifdef DROP_ON_FULL_EN
        step();
        check_val("t5_drop_ack", bus.ack_out, 1);
        check_val("t5_drop_one", bus.drop_cnt_out, 1);
        for (int k = 0; k < 1000; k++) begin
            drive_proto(1'b1);
            step();
        end
        check_val("t5_drop_sat", bus.drop_cnt_out, 255);
`else
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            cnt += int'(bus.enq_out) + int'(bus.ack_out);
        end
        check_val("t5_backpressure", cnt, 0);
        check_val("t5_drop_zero", bus.drop_cnt_out, 0);
`endif
        bus.des_ready_in = 1'b0;
        settle();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) != 0) drive_proto(1'b1);
            if ($urandom_range(0, 4) == 0) bus.deq_req_in = ~bus.deq_req_in;
            if ($urandom_range(0, 5) == 0) bus.len_in = 4'($urandom_range(0, DEPTH));
            if ($urandom_range(0, 599) == 0) apply_reset();
            else step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
